// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction-fetch front end. Issues sequential, word-aligned fetch requests
// over a valid/ready memory port, tolerates variable memory latency with up
// to MAX_OUTSTANDING requests in flight, and buffers returned instructions
// together with their PCs in a DEPTH-entry queue that feeds decode. A
// redirect flushes the queue, restarts fetch at the new target and discards
// every response still in flight for the old path.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   reset           : asynchronous active-low reset
//   imem_req_valid  : fetch request valid
//   imem_req_ready  : memory accepts the request
//   imem_req_addr   : fetch address (word aligned)
//   imem_rsp_valid  : response valid (responses return in request order)
//   imem_rsp_data   : returned instruction
//   out_valid       : queue head valid
//   out_ready       : decode consumes the head
//   out_instr       : head instruction (0 while the queue is empty)
//   out_pc          : head PC (0 while the queue is empty)
//   redirect_valid  : taken branch/jump, flush and refetch
//   redirect_pc     : new fetch target, bits [1:0] are ignored
//   queue_count     : number of occupied queue entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int unsigned     XLEN            = 64,
  parameter int unsigned     ILEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [ILEN-1:0]          imem_rsp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ILEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  // Queue storage and bookkeeping
  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  ptr_t            rd_ptr;
  ptr_t            wr_ptr;
  cnt_t            count;
  cnt_t            outstanding;   // accepted requests not yet answered
  cnt_t            drop_count;    // in-flight responses belonging to a flushed path
  logic [XLEN-1:0] fetch_pc;      // address of the next request
  logic [XLEN-1:0] rsp_pc;        // PC of the next response to be kept

  logic            req_fire;
  logic            rsp_accept;
  logic            rsp_keep;
  logic            pop;
  cnt_t            in_use;
  cnt_t            outstanding_left;
  logic [XLEN-1:0] redirect_target;
  logic            unused_pc_bits;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_pc_bits  = ^redirect_pc[1:0];

  // Credit rule: a slot is reserved for every request in flight, so the sum
  // of queued and outstanding entries never exceeds DEPTH and responses never
  // need backpressure.
  assign in_use         = count + outstanding;
  assign imem_req_valid = reset && !redirect_valid
                       && (in_use < cnt_t'(DEPTH))
                       && (outstanding < cnt_t'(MAX_OUTSTANDING));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_accept       = imem_rsp_valid && (outstanding != '0);
  // Responses are discarded while stale ones drain or when they coincide
  // with a redirect.
  assign rsp_keep         = rsp_accept && !redirect_valid && (drop_count == '0);
  assign outstanding_left = outstanding - cnt_t'(rsp_accept);

  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;
  assign queue_count = count;

  // Gating the head keeps the outputs at zero while empty, so the storage
  // itself never needs a reset value.
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;

  // NOTE: storage arrays are deliberately left out of reset; validity is
  // tracked by count/pointers alone, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      instr_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]    <= rsp_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_count  <= '0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
    end else if (redirect_valid) begin
      // Flush takes priority over push/pop; a same-cycle pop is simply lost
      // with the rest of the queue, and everything still in flight after this
      // cycle's response belongs to the old path.
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_pc    <= redirect_target;
      rsp_pc      <= redirect_target;
      outstanding <= outstanding_left;
      drop_count  <= outstanding_left;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (rsp_keep) begin
        wr_ptr <= wr_ptr + 1'b1;
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count       <= count + cnt_t'(rsp_keep) - cnt_t'(pop);
      outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_accept);
      if (rsp_accept && (drop_count != '0)) begin
        drop_count <= drop_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_unit
//
// Directed bench for fetch_queue_unit. A bench-side memory returns responses
// in order after a programmable latency; every kept response is pushed to an
// expected-output queue and popped/compared when decode consumes the head.
// A second instance with RESET_PC near the top of the address space covers
// PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_queue_unit;

  localparam int          DEPTH   = 4;
  localparam int          MAXO    = 2;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [2:0]  queue_count;

  logic        w_req_valid;
  logic [63:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [63:0] w_out_pc;
  logic [2:0]  w_queue_count;
  logic        w_req_ready = 1'b1;
  logic        w_out_ready = 1'b1;
  logic        w_redirect_valid = 1'b0;
  logic [63:0] w_redirect_pc = 64'h0;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .XLEN(64), .ILEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(64'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .queue_count(queue_count)
  );

  fetch_queue_unit #(
    .XLEN(64), .ILEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(WRAP_PC)
  ) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_instr(w_out_instr), .out_pc(w_out_pc),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .queue_count(w_queue_count)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  mreq_t       mem_q[$];
  ent_t        exp_q[$];
  logic [63:0] req_log[$];
  logic [63:0] w_req_log[$];
  logic [63:0] w_pc_log[$];
  logic [31:0] w_instr_log[$];

  int          cyc;
  int          lat;
  int          checks;
  int          errors;
  int          n_req;
  int          n_pop;
  int          first_fire_cyc;
  int          first_valid_cyc;
  logic [63:0] model_pc;
  logic [63:0] last_req_addr;
  logic [63:0] last_pop_pc;
  logic        w_prev_fire;
  logic [63:0] w_prev_addr;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory responses, compare against the model,
  // update the model, then advance to just after the next rising edge.
  task automatic tick();
    bit    deliver;
    bit    exp_req_valid;
    mreq_t r;
    ent_t  e;
    deliver        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = deliver;
    imem_rsp_data  = deliver ? instr_of(mem_q[0].addr) : 32'h0;
    w_rsp_valid    = w_prev_fire;
    w_rsp_data     = instr_of(w_prev_addr);
    #2;
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("queue_count", 64'(queue_count), 64'(exp_q.size()));
    exp_req_valid = !redirect_valid && (exp_q.size() + mem_q.size() < DEPTH)
                 && (mem_q.size() < MAXO);
    check("req_valid", 64'(imem_req_valid), 64'(exp_req_valid));
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_pc", out_pc, e.pc);
      check("out_instr", 64'(out_instr), 64'(e.instr));
      last_pop_pc = out_pc;
      n_pop++;
    end
    if (redirect_valid) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_q.delete();
      model_pc = {redirect_pc[63:2], 2'b00};
    end
    if (deliver) begin
      r = mem_q.pop_front();
      if (!r.stale) begin
        e.pc    = r.addr;
        e.instr = instr_of(r.addr);
        exp_q.push_back(e);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, model_pc);
      model_pc = model_pc + 64'd4;
      r.addr   = imem_req_addr;
      r.due    = cyc + lat;
      r.stale  = 1'b0;
      mem_q.push_back(r);
      if (first_fire_cyc < 0) first_fire_cyc = cyc;
      if (req_log.size() < 4) req_log.push_back(imem_req_addr);
      last_req_addr = imem_req_addr;
      n_req++;
    end
    if (w_out_valid && w_pc_log.size() < 4) begin
      w_pc_log.push_back(w_out_pc);
      w_instr_log.push_back(w_out_instr);
    end
    if (w_req_valid && w_req_log.size() < 4) w_req_log.push_back(w_req_addr);
    w_prev_fire = w_req_valid;
    w_prev_addr = w_req_addr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    w_rsp_valid    = 1'b0;
    w_prev_fire    = 1'b0;
    mem_q.delete();
    exp_q.delete();
    model_pc = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    cyc += 2;
    reset = 1'b1;
  endtask

  initial begin
    int          n0;
    int          budget;
    logic [63:0] exp_wrap [4];
    exp_wrap[0] = WRAP_PC;
    exp_wrap[1] = WRAP_PC + 64'd4;
    exp_wrap[2] = 64'h0;
    exp_wrap[3] = 64'h4;

    checks = 0; errors = 0; cyc = 0; lat = 1; n_req = 0; n_pop = 0;
    first_fire_cyc = -1; first_valid_cyc = -1;
    model_pc = 64'h0; last_req_addr = '0; last_pop_pc = '0;
    w_prev_fire = 1'b0; w_prev_addr = 64'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    w_rsp_valid = 1'b0; w_rsp_data = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_queue_count", 64'(queue_count), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);

    // Streaming from reset, latency 1, decode always ready
    reset = 1'b1; imem_req_ready = 1'b1; out_ready = 1'b1; lat = 1;
    for (int i = 0; i < 40 && n_pop < 4; i++) tick();
    check("p1_pops", 64'(n_pop), 64'd4);
    for (int i = 0; i < 4; i++)
      check("p1_req_order", (i < req_log.size()) ? req_log[i] : 64'hx, 64'(4 * i));
    check("p1_first_valid_latency", 64'(first_valid_cyc - first_fire_cyc), 64'd2);
    repeat (3) tick();

    // PC wrap on the second instance
    for (int i = 0; i < 4; i++) begin
      check("wrap_req_addr", (i < w_req_log.size()) ? w_req_log[i] : 64'hx, exp_wrap[i]);
      check("wrap_out_pc", (i < w_pc_log.size()) ? w_pc_log[i] : 64'hx, exp_wrap[i]);
      check("wrap_out_instr",
            (i < w_instr_log.size()) ? 64'(w_instr_log[i]) : 64'hx,
            64'(instr_of(exp_wrap[i])));
    end

    // Backpressure: fill the queue, fetch must stall, then drain and resume
    do_reset();
    out_ready = 1'b0; lat = 1;
    budget = 0;
    while (queue_count != 3'd4 && budget < 30) begin tick(); budget++; end
    check("p2_full", 64'(queue_count), 64'd4);
    repeat (3) tick();
    check("p2_req_blocked", 64'(imem_req_valid), 64'd0);
    out_ready = 1'b1;
    n0 = n_pop;
    n_req = 0;
    budget = 0;
    while (n_req == 0 && budget < 20) begin tick(); budget++; end
    check("p2_resume_addr", last_req_addr, 64'h10);
    budget = 0;
    while (n_pop - n0 < 4 && budget < 20) begin tick(); budget++; end
    check("p2_drain_pops", 64'(n_pop - n0), 64'd4);

    // Redirect with two requests in flight at latency 3
    lat = 3;
    budget = 0;
    while (mem_q.size() != 2 && budget < 20) begin tick(); budget++; end
    check("p3_two_outstanding", 64'(mem_q.size()), 64'd2);
    redirect_valid = 1'b1; redirect_pc = 64'h103;
    tick();
    redirect_valid = 1'b0;
    n0 = n_req;
    budget = 0;
    while (n_req == n0 && budget < 20) begin tick(); budget++; end
    check("p3_next_req_addr", last_req_addr, 64'h100);
    n0 = n_pop;
    budget = 0;
    while (n_pop == n0 && budget < 30) begin tick(); budget++; end
    check("p3_first_out_pc", last_pop_pc, 64'h100);

    // Redirect, response and pop in the same cycle
    out_ready = 1'b0; lat = 2;
    budget = 0;
    while (!(exp_q.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc) && budget < 40) begin
      tick(); budget++;
    end
    check("p4_setup_found", 64'(budget < 40), 64'd1);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h200;
    tick();
    redirect_valid = 1'b0;
    check("p4_queue_empty", 64'(queue_count), 64'd0);
    check("p4_out_valid", 64'(out_valid), 64'd0);
    n0 = n_pop;
    budget = 0;
    while (n_pop == n0 && budget < 30) begin tick(); budget++; end
    check("p4_first_out_pc", last_pop_pc, 64'h200);

    // Asynchronous reset with three entries queued
    lat = 1; out_ready = 1'b0;
    budget = 0;
    while (exp_q.size() != 3 && budget < 30) begin tick(); budget++; end
    check("p6_three_queued", 64'(queue_count), 64'd3);
    reset = 1'b0;
    #1;
    check("p6_async_out_valid", 64'(out_valid), 64'd0);
    check("p6_async_req_valid", 64'(imem_req_valid), 64'd0);
    check("p6_async_count", 64'(queue_count), 64'd0);
    do_reset();
    out_ready = 1'b1;
    n0 = n_req;
    budget = 0;
    while (n_req == n0 && budget < 20) begin tick(); budget++; end
    check("p6_restart_addr", last_req_addr, 64'h0);
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
